// File: rtl/exc_commit.sv
// Writeback-stage exception commit: classifies the retiring instruction, pulses
// the CP0 exception/eret strobes and holds a flush plus fetch redirect until accepted.
module exc_commit #(
   parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
   parameter int          EXC_W      = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             ws_valid,
   output logic             ws_ready,
   input  logic [31:0]      ws_pc,
   input  logic             ws_is_slot,
   input  logic [6:0]       ws_exc,
   input  logic [31:0]      ws_bad_vaddr,
   input  logic             ws_eret,
   input  logic             int_happen,
   input  logic [31:0]      cp0_epc,
   output logic [EXC_W-1:0] exc_type,
   output logic [31:0]      exc_pc,
   output logic             exc_is_slot,
   output logic [31:0]      exc_bad_vaddr,
   output logic             eret,
   output logic             flush,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [31:0]      redirect_pc
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } state_t;

   localparam int B_OV   = 0;
   localparam int B_RI   = 1;
   localparam int B_BP   = 2;
   localparam int B_SYS  = 3;
   localparam int B_ADES = 4;
   localparam int B_RDAE = 5;
   localparam int B_RINE = 6;
   localparam int B_INT  = 7;

   // Priority int > rine > ri > sys > bp > ov > rdae > ades; result is one-hot or zero.
   function automatic logic [EXC_W-1:0] pick_cause(input logic irq, input logic [6:0] f);
      logic [EXC_W-1:0] code;
      code = '0;
      if (irq)              code[B_INT]  = 1'b1;
      else if (f[B_RINE])   code[B_RINE] = 1'b1;
      else if (f[B_RI])     code[B_RI]   = 1'b1;
      else if (f[B_SYS])    code[B_SYS]  = 1'b1;
      else if (f[B_BP])     code[B_BP]   = 1'b1;
      else if (f[B_OV])     code[B_OV]   = 1'b1;
      else if (f[B_RDAE])   code[B_RDAE] = 1'b1;
      else if (f[B_ADES])   code[B_ADES] = 1'b1;
      return code;
   endfunction

   // A fetch-side fault reports the PC itself as the bad address.
   function automatic logic [31:0] pick_bad_vaddr(input logic [EXC_W-1:0] code,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] data_addr);
      return code[B_RINE] ? pc : data_addr;
   endfunction

   state_t           state_q, state_d;
   logic             vld_p0;
   logic             irq_p0;
   logic [EXC_W-1:0] cause_p0;
   logic             take_exc_p0;

   logic [EXC_W-1:0] exc_type_p1, exc_type_d;
   logic             eret_p1, eret_d;
   logic [31:0]      exc_pc_p1, exc_pc_d;
   logic             exc_is_slot_p1, exc_is_slot_d;
   logic [31:0]      exc_bad_vaddr_p1, exc_bad_vaddr_d;
   logic [31:0]      redirect_pc_p1, redirect_pc_d;
   logic             flush_p1, flush_d;
   logic             vld_p1, vld_d;

   // Stage p0: classify the retiring instruction.
   assign ws_ready    = (state_q == IDLE);
   assign vld_p0      = ws_valid && ws_ready;
   assign irq_p0      = int_happen && ws_valid;
   assign cause_p0    = pick_cause(irq_p0, ws_exc);
   assign take_exc_p0 = |cause_p0;

   always_comb begin
      state_d          = state_q;
      exc_type_d       = '0;
      eret_d           = 1'b0;
      exc_pc_d         = exc_pc_p1;
      exc_is_slot_d    = exc_is_slot_p1;
      exc_bad_vaddr_d  = exc_bad_vaddr_p1;
      redirect_pc_d    = redirect_pc_p1;
      flush_d          = flush_p1;
      vld_d            = vld_p1;
      case (state_q)
         IDLE: begin
            if (vld_p0 && take_exc_p0) begin
               exc_type_d      = cause_p0;
               exc_pc_d        = ws_pc;
               exc_is_slot_d   = ws_is_slot;
               exc_bad_vaddr_d = pick_bad_vaddr(cause_p0, ws_pc, ws_bad_vaddr);
               redirect_pc_d   = EXC_VECTOR;
               flush_d         = 1'b1;
               vld_d           = 1'b1;
               state_d         = REDIR;
            end else if (vld_p0 && ws_eret) begin
               eret_d        = 1'b1;
               redirect_pc_d = cp0_epc;
               flush_d       = 1'b1;
               vld_d         = 1'b1;
               state_d       = REDIR;
            end
         end
         REDIR: begin
            if (vld_p1 && redirect_ready) begin
               flush_d = 1'b0;
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            flush_d = 1'b0;
            vld_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Stage p1: registered CP0 strobes and redirect request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exc_type_p1      <= '0;
         eret_p1          <= 1'b0;
         exc_pc_p1        <= '0;
         exc_is_slot_p1   <= 1'b0;
         exc_bad_vaddr_p1 <= '0;
         redirect_pc_p1   <= '0;
         flush_p1         <= 1'b0;
         vld_p1           <= 1'b0;
      end else begin
         exc_type_p1      <= exc_type_d;
         eret_p1          <= eret_d;
         exc_pc_p1        <= exc_pc_d;
         exc_is_slot_p1   <= exc_is_slot_d;
         exc_bad_vaddr_p1 <= exc_bad_vaddr_d;
         redirect_pc_p1   <= redirect_pc_d;
         flush_p1         <= flush_d;
         vld_p1           <= vld_d;
      end
   end

   assign exc_type       = exc_type_p1;
   assign eret           = eret_p1;
   assign exc_pc         = exc_pc_p1;
   assign exc_is_slot    = exc_is_slot_p1;
   assign exc_bad_vaddr  = exc_bad_vaddr_p1;
   assign redirect_pc    = redirect_pc_p1;
   assign flush          = flush_p1;
   assign redirect_valid = vld_p1;

endmodule
